reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
Clocked, parametrised successor to the combinational MIPS register bank. Provides two asynchronous read ports and one synchronous write port, with register 0 optionally hardwired to zero and optional write-to-read bypass. Adds a per-register busy scoreboard, set at instruction issue and cleared at writeback, so the decode stage can detect RAW hazards. Sits between decode (reads, issue) and writeback (write).

Parameters:
DATA_W, 32, data width of each register.
ADDR_W, 5, address width; depth = 2**ADDR_W registers.
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports and clears their busy indication.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
rAddr1  in  ADDR_W  read port 1 address.
rAddr2  in  ADDR_W  read port 2 address.
data1  out  DATA_W  read port 1 data (combinational).
data2  out  DATA_W  read port 2 data (combinational).
busy1  out  1  register at rAddr1 has a pending producer.
busy2  out  1  register at rAddr2 has a pending producer.
wAddr  in  ADDR_W  write address.
wrData  in  DATA_W  write data.
regWriteFlag  in  1  write enable, sampled at the rising edge of clk.
issueValid  in  1  mark issueAddr busy at the next edge.
issueAddr  in  ADDR_W  destination register of the issuing instruction.
busyCount  out  ADDR_W+1  number of registers currently busy (registered).

Behaviour:
- Reset: rst_n low clears all registers, all busy bits and busyCount to 0 immediately, without waiting for clk. data*/busy* then read 0. Reset mid-operation discards pending writes and issues.
- Write: at posedge clk with regWriteFlag=1, reg[wAddr] <= wrData. If ZERO_REG=1 and wAddr=0, no state changes.
- Read: data_k = reg[rAddr_k] combinationally. With ZERO_REG=1 and rAddr_k=0, data_k=0 regardless of state.
- Bypass (BYPASS=1): if regWriteFlag=1, rAddr_k=wAddr and the write is legal, data_k=wrData in the same cycle. With BYPASS=0, the new value appears only after the edge.
- Scoreboard: busy[n] is set at the edge when issueValid=1 and issueAddr=n. It is cleared at the edge when a legal write hits n.
- Same-edge set and clear on the same address: set wins, because the new producer supersedes the old one.
- issueValid to an already-busy register keeps it busy. There is no nesting and no count per register.
- Write to a non-busy register is legal: data is written and the busy bit stays 0.
- busy_k = busy[rAddr_k], forced to 0 when rAddr_k=0 with ZERO_REG=1. With BYPASS=1, busy_k is also forced to 0 when a legal write to rAddr_k occurs in the same cycle and issueAddr does not hit rAddr_k.
- busyCount: registered popcount of the busy bits, updated at every edge. Per edge it changes by -1, 0 or +1. Range is 0 to 2**ADDR_W (or 2**ADDR_W - 1 with ZERO_REG=1). It never wraps.
- Both read ports may address the same register; each port resolves independently.
- No X propagation: all storage is reset, so reads before any write return 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after writing reg[5]=0xDEADBEEF -> data1 at rAddr1=5 reads 0 immediately; busyCount=0.
- Zero register: write wAddr=0, wrData=0xFFFFFFFF, then issueValid on issueAddr=0 -> data1 at rAddr1=0 reads 0; busy1=0; busyCount stays 0.
- Write/read with bypass: in a single cycle set regWriteFlag=1, wAddr=7, wrData=0x12345678, rAddr1=rAddr2=7 -> both data ports read 0x12345678 in that cycle. With BYPASS=0 they show the old value (0) until the edge.
- Scoreboard lifecycle: issue reg 3, then next cycle issue reg 9 -> busyCount 1 then 2. Write reg 3 -> busy1 at rAddr1=3 drops in the write cycle (BYPASS=1) and busyCount=1 after the edge.
- Simultaneous events: on one edge, issueValid=1, issueAddr=4 and a write to wAddr=4 while reg 4 is busy -> reg 4 gets the data, busy stays 1, busyCount unchanged.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> write all 8 regs, issue all 7 non-zero regs -> busyCount=7; read back each value with no aliasing.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register bank with two combinational read ports, one synchronous write port
// and a per-register busy scoreboard for RAW hazard detection at decode.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rAddr1,
    input  logic [ADDR_W-1:0] rAddr2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              regWriteFlag,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    output logic [ADDR_W:0]   busyCount
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              writeLegal;
    logic              issueLegal;
    logic              countInc;
    logic              countDec;

    always_comb begin
        writeLegal = regWriteFlag && !(ZERO_REG != 0 && wAddr == '0);
        issueLegal = issueValid && !(ZERO_REG != 0 && issueAddr == '0);
        // Count moves only on real transitions; a same-address issue keeps the bit set.
        countInc   = issueLegal && !busy[issueAddr];
        countDec   = writeLegal && busy[wAddr] && !(issueLegal && issueAddr == wAddr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (writeLegal) begin
            regs[wAddr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            busyCount <= '0;
        end else begin
            if (writeLegal) busy[wAddr] <= 1'b0;
            // Issued later in the block so a new producer wins over writeback.
            if (issueLegal) busy[issueAddr] <= 1'b1;
            busyCount <= busyCount + {{ADDR_W{1'b0}}, countInc} - {{ADDR_W{1'b0}}, countDec};
        end
    end

    always_comb begin
        data1 = regs[rAddr1];
        if (BYPASS != 0 && writeLegal && rAddr1 == wAddr) data1 = wrData;
        if (ZERO_REG != 0 && rAddr1 == '0) data1 = '0;

        data2 = regs[rAddr2];
        if (BYPASS != 0 && writeLegal && rAddr2 == wAddr) data2 = wrData;
        if (ZERO_REG != 0 && rAddr2 == '0) data2 = '0;
    end

    always_comb begin
        busy1 = busy[rAddr1];
        if (BYPASS != 0 && writeLegal && rAddr1 == wAddr && !(issueValid && issueAddr == rAddr1))
            busy1 = 1'b0;
        if (ZERO_REG != 0 && rAddr1 == '0) busy1 = 1'b0;

        busy2 = busy[rAddr2];
        if (BYPASS != 0 && writeLegal && rAddr2 == wAddr && !(issueValid && issueAddr == rAddr2))
            busy2 = 1'b0;
        if (ZERO_REG != 0 && rAddr2 == '0) busy2 = 1'b0;
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: behavioural model compared every cycle plus
// directed literal checks, covering bypass/no-bypass and a small-geometry instance.
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rAddr1 = '0, rAddr2 = '0, wAddr = '0, issueAddr = '0;
    logic [31:0] wrData = '0;
    logic        regWriteFlag = 1'b0, issueValid = 1'b0;

    logic [31:0] data1, data2, nbData1, nbData2;
    logic        busy1, busy2, nbBusy1, nbBusy2;
    logic [5:0]  busyCount, nbBusyCount;

    logic [2:0]  sAddr1 = '0, sAddr2 = '0, sWAddr = '0, sIssueAddr = '0;
    logic [15:0] sWrData = '0;
    logic        sWrite = 1'b0, sIssue = 1'b0;
    logic [15:0] sData1, sData2;
    logic        sBusy1, sBusy2;
    logic [3:0]  sBusyCount;

    int tests = 0;
    int fails = 0;
    bit chkOn = 1'b0;

    always #5 clk = ~clk;

    reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rAddr1(rAddr1), .rAddr2(rAddr2),
        .data1(data1), .data2(data2), .busy1(busy1), .busy2(busy2),
        .wAddr(wAddr), .wrData(wrData), .regWriteFlag(regWriteFlag),
        .issueValid(issueValid), .issueAddr(issueAddr), .busyCount(busyCount));

    reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dutNb (
        .clk(clk), .rst_n(rst_n), .rAddr1(rAddr1), .rAddr2(rAddr2),
        .data1(nbData1), .data2(nbData2), .busy1(nbBusy1), .busy2(nbBusy2),
        .wAddr(wAddr), .wrData(wrData), .regWriteFlag(regWriteFlag),
        .issueValid(issueValid), .issueAddr(issueAddr), .busyCount(nbBusyCount));

    reg_file_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dutSmall (
        .clk(clk), .rst_n(rst_n), .rAddr1(sAddr1), .rAddr2(sAddr2),
        .data1(sData1), .data2(sData2), .busy1(sBusy1), .busy2(sBusy2),
        .wAddr(sWAddr), .wrData(sWrData), .regWriteFlag(sWrite),
        .issueValid(sIssue), .issueAddr(sIssueAddr), .busyCount(sBusyCount));

    // Model: architectural contents and the set of registers awaiting a producer.
    logic [31:0] mRegs [32];
    bit          mBusy [32];
    int          mCount = 0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = '0;
            mBusy[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
            mCount = 0;
        end else begin
            if (regWriteFlag && wAddr != 0) begin
                mRegs[wAddr] = wrData;
                mBusy[wAddr] = 1'b0;
            end
            if (issueValid && issueAddr != 0) mBusy[issueAddr] = 1'b1;
            mCount = 0;
            for (int i = 0; i < 32; i++) mCount += int'(mBusy[i]);
        end
    end

    function automatic logic [31:0] expData(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && regWriteFlag && wAddr == a) return wrData;
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && regWriteFlag && wAddr == a && !(issueValid && issueAddr == a)) return 1'b0;
        return mBusy[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chkOn) begin
            chk("data1",     data1,            expData(rAddr1, 1'b1));
            chk("data2",     data2,            expData(rAddr2, 1'b1));
            chk("busy1",     {31'd0, busy1},   {31'd0, expBusy(rAddr1, 1'b1)});
            chk("busy2",     {31'd0, busy2},   {31'd0, expBusy(rAddr2, 1'b1)});
            chk("busyCount", {26'd0, busyCount}, mCount);
            chk("nbData1",   nbData1,          expData(rAddr1, 1'b0));
            chk("nbData2",   nbData2,          expData(rAddr2, 1'b0));
            chk("nbBusy1",   {31'd0, nbBusy1}, {31'd0, expBusy(rAddr1, 1'b0)});
            chk("nbBusy2",   {31'd0, nbBusy2}, {31'd0, expBusy(rAddr2, 1'b0)});
            chk("nbBusyCount", {26'd0, nbBusyCount}, mCount);
        end
    end

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic v, input logic [4:0] ia);
        @(negedge clk);
        regWriteFlag = w; wAddr = wa; wrData = wd;
        rAddr1 = a1; rAddr2 = a2; issueValid = v; issueAddr = ia;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("resetCount", {26'd0, busyCount}, 32'd0);
        chk("resetData", data1, 32'd0);
        chkOn = 1'b1;

        // Mid-cycle reset wipes a written register immediately.
        drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
        drive(0, 0, 0, 5, 0, 0, 0);
        chk("reg5Written", data1, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncResetData", data1, 32'd0);
        chk("asyncResetCount", {26'd0, busyCount}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Register 0 ignores writes and issues.
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("zeroData", data1, 32'd0);
        chk("zeroBusy", {31'd0, busy1}, 32'd0);
        chk("zeroCount", {26'd0, busyCount}, 32'd0);

        // Same-cycle bypass vs. none.
        drive(1, 7, 32'h12345678, 7, 7, 0, 0);
        chk("bypass1", data1, 32'h12345678);
        chk("bypass2", data2, 32'h12345678);
        chk("noBypass1", nbData1, 32'd0);
        chk("noBypass2", nbData2, 32'd0);
        drive(0, 0, 0, 7, 7, 0, 0);
        chk("noBypassAfter", nbData1, 32'h12345678);

        // Scoreboard lifecycle.
        drive(0, 0, 0, 3, 9, 1, 3);
        drive(0, 0, 0, 3, 9, 1, 9);
        chk("count1", {26'd0, busyCount}, 32'd1);
        chk("busy3", {31'd0, busy1}, 32'd1);
        drive(1, 3, 32'h0000AAAA, 3, 9, 0, 0);
        chk("busy3Bypassed", {31'd0, busy1}, 32'd0);
        chk("busy3NoBypass", {31'd0, nbBusy1}, 32'd1);
        chk("count2", {26'd0, busyCount}, 32'd2);
        drive(0, 0, 0, 3, 9, 0, 0);
        chk("countAfterWb", {26'd0, busyCount}, 32'd1);
        chk("data3", data1, 32'h0000AAAA);
        chk("busy9", {31'd0, busy2}, 32'd1);

        // Same-edge issue and write on a busy register: set wins.
        drive(0, 0, 0, 4, 0, 1, 4);
        drive(1, 4, 32'h44444444, 4, 0, 1, 4);
        chk("simulCount", {26'd0, busyCount}, 32'd2);
        chk("simulBusyHeld", {31'd0, busy1}, 32'd1);
        drive(0, 0, 0, 4, 0, 0, 0);
        chk("simulCountAfter", {26'd0, busyCount}, 32'd2);
        chk("simulBusyAfter", {31'd0, busy1}, 32'd1);
        chk("simulData", data1, 32'h44444444);

        // Write one busy register while issuing another: count holds; re-issue busy reg.
        drive(1, 9, 32'h99999999, 9, 10, 1, 10);
        drive(0, 0, 0, 9, 10, 1, 4);
        chk("swapCount", {26'd0, busyCount}, 32'd2);

        // Mixed traffic over every address, then drain all producers.
        for (int i = 1; i < 32; i++)
            drive(1, 5'(i), 32'hA5000000 ^ (32'(i) * 32'h01010101), 5'(i), 5'(i - 1),
                  (i % 3) == 0, 5'(i / 2));
        for (int i = 1; i < 32; i++)
            drive(1, 5'(i), 32'(i) * 32'h11, 5'(32 - i), 5'(i), 0, 0);
        drive(0, 0, 0, 31, 1, 0, 0);
        chk("drainedCount", {26'd0, busyCount}, 32'd0);
        chk("drainedData", data1, 32'h0000020F);

        // Small geometry: fill, mark all busy, read back without aliasing.
        chkOn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sWrite = 1'b1; sWAddr = 3'(i); sWrData = 16'h1000 + 16'(i) * 16'h0111;
        end
        @(negedge clk);
        sWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sIssue = 1'b1; sIssueAddr = 3'(i);
        end
        @(negedge clk);
        sIssue = 1'b0;
        #1;
        chk("smallCount", {28'd0, sBusyCount}, 32'd7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sAddr1 = 3'(i); sAddr2 = 3'(7 - i);
            #1;
            chk("smallData1", {16'd0, sData1}, (i == 0) ? 32'd0 : 32'h1000 + 32'(i) * 32'h0111);
            chk("smallData2", {16'd0, sData2}, (i == 7) ? 32'd0 : 32'h1000 + 32'(7 - i) * 32'h0111);
            chk("smallBusy1", {31'd0, sBusy1}, (i == 0) ? 32'd0 : 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
